// File: rtl/bus_mem_bist.sv
// bus_mem_bist: bus-master memory self-test that writes an address pattern, reads it back and compares.
// Define BIST_TIMEOUT_EN to bound the wait for slave completion by TIMEOUT cycles.
`default_nettype none

module bus_mem_bist #(
  parameter int BUS_WIDTH  = 32,
  parameter int CTRL_WIDTH = 8,
  parameter int ADDR_WIDTH = 23
`ifdef BIST_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 255
`endif
) (
  input  logic                  clk50MHz,
  input  logic                  rst_L,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  output logic                  bus_req,
  input  logic                  bus_ack,
  input  logic [BUS_WIDTH-1:0]  bus_in,
  input  logic [CTRL_WIDTH-1:0] ctrl_in,
  output logic [BUS_WIDTH-1:0]  bus_out,
  output logic [CTRL_WIDTH-1:0] ctrl_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [7:0]            err_count,
  output logic [7:0]            debug_out
);

  localparam logic [CTRL_WIDTH-1:0] CTRL_IDLE  = CTRL_WIDTH'(8'h00);
  localparam logic [CTRL_WIDTH-1:0] CTRL_READ  = CTRL_WIDTH'(8'h01);
  localparam logic [CTRL_WIDTH-1:0] CTRL_WRITE = CTRL_WIDTH'(8'h02);
  localparam logic [CTRL_WIDTH-1:0] CTRL_DONE  = CTRL_WIDTH'(8'h80);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_REQ     = 4'd1,
    S_ADDR    = 4'd2,
    S_DATA    = 4'd3,
    S_WAIT    = 4'd4,
    S_RELEASE = 4'd5,
    S_FINISH  = 4'd6
  } state_t;

  state_t                state;
  logic                  phase;          // 0 = write pass, 1 = read-back pass
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [ADDR_WIDTH-1:0] remaining;
  logic                  timeout_flag;
  logic                  slave_done;
  logic                  data_bad;
  logic                  timed_out;
  logic                  err_event;

  function automatic logic [BUS_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    logic [15:0] lo;
    lo = 16'(a);
    return BUS_WIDTH'({~lo, lo});
  endfunction

  assign slave_done = (ctrl_in == CTRL_DONE);
  assign data_bad   = phase && slave_done && (bus_in != pattern(addr));

`ifdef BIST_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TO_W-1:0] wait_cnt;
  assign timed_out = !slave_done && (wait_cnt == TO_W'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  // Only the read-back pass has data to compare, so only it can record errors.
  assign err_event = (state == S_WAIT) && bus_ack && phase && (data_bad || timed_out);

  assign debug_out = {state, phase, timeout_flag, 2'b00};

  always_ff @(posedge clk50MHz or negedge rst_L) begin
    if (!rst_L) begin
      state        <= S_IDLE;
      phase        <= 1'b0;
      addr         <= '0;
      base_q       <= '0;
      count_q      <= '0;
      remaining    <= '0;
      bus_req      <= 1'b0;
      bus_out      <= '0;
      ctrl_out     <= CTRL_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_addr    <= '0;
      err_count    <= '0;
      timeout_flag <= 1'b0;
`ifdef BIST_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      bus_out  <= '0;
      ctrl_out <= CTRL_IDLE;
`ifdef BIST_TIMEOUT_EN
      if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                 wait_cnt <= '0;
`endif
      if (err_event) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (err_count == 8'h00) fail_addr <= addr;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            base_q       <= base_addr;
            count_q      <= word_count;
            remaining    <= word_count;
            addr         <= base_addr;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_addr    <= '0;
            timeout_flag <= 1'b0;
            phase        <= 1'b0;
            busy         <= 1'b1;
            if (word_count == '0) begin
              state <= S_FINISH;
            end else begin
              bus_req <= 1'b1;
              state   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            bus_out  <= BUS_WIDTH'(addr);
            ctrl_out <= phase ? CTRL_READ : CTRL_WRITE;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (!bus_ack) begin
            state <= S_REQ;
          end else if (!phase) begin
            bus_out  <= pattern(addr);
            ctrl_out <= CTRL_WRITE;
            state    <= S_DATA;
          end else begin
            state <= S_WAIT;
          end
        end
        S_DATA: begin
          if (!bus_ack) state <= S_REQ;
          else          state <= S_WAIT;
        end
        S_WAIT: begin
          // Losing the grant abandons the transaction; it is re-issued at the same address.
          if (!bus_ack) begin
            state <= S_REQ;
          end else if (slave_done || timed_out) begin
            if (timed_out) timeout_flag <= 1'b1;
            bus_req <= 1'b0;
            state   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          addr      <= addr + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == ADDR_WIDTH'(1)) begin
            if (!phase) begin
              phase     <= 1'b1;
              addr      <= base_q;
              remaining <= count_q;
              bus_req   <= 1'b1;
              state     <= S_REQ;
            end else begin
              state <= S_FINISH;
            end
          end else begin
            bus_req <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == 8'h00);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
